serial_slave_port: RTL and testbench
====================================

Name: serial_slave_port

Overview:
- Slave-side endpoint of the serial bus: the block an arbiter slave port (sN_*) drives into.
- Deserialises an in-slave word address and, on writes, a data word; stores it in a local memory.
- On reads, fetches a word and serialises it back toward the master on data_out with valid_out.
- Supports single and incrementing-burst transfers; a stalled transfer is aborted after a timeout.

Parameters:
ADDR_WIDTH, 11, in-slave word-address bits, sent MSB first on address
DATA_WIDTH, 8, data word bits, sent MSB first on data and data_out
TIMEOUT, 16, consecutive valid-low cycles in ADDR/WDATA before abort

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
address  in  1  serial address bit, qualified by valid
data  in  1  serial write-data bit, qualified by valid
valid  in  1  bit strobe from arbiter; low while the arbiter consumes its slave-select bits
write_en  in  1  1=write, 0=read; sampled on first valid of a transfer
burst  in  1  sampled at each word boundary; 1=continue to next address
data_out  out  1  serial read-data bit, MSB first
ready  out  1  slave can accept bits
valid_out  out  1  qualifies data_out
state  out  3  current FSM state, for test visibility

Behaviour:
- Reset low (async): state=IDLE, ready=0, valid_out=0, data_out=0, counters/shift regs cleared. Memory contents not reset and preserved across reset. After release: ready=1 in IDLE.
- States: IDLE=0, ADDR=1, WDATA=2, WCOMMIT=3, RFETCH=4, RDATA=5.
- IDLE: ready=1. First cycle with valid=1 shifts address bit in, latches write_en and burst, bit_cnt=1, goes to ADDR (or straight on if ADDR_WIDTH=1).
- ADDR: ready=1. Each valid=1 cycle shifts one address bit; valid=0 holds. After bit ADDR_WIDTH: write goes to WDATA, read goes to RFETCH.
- WDATA: ready=1. Each valid=1 cycle shifts one data bit. After DATA_WIDTH bits goes to WCOMMIT.
- WCOMMIT: exactly 1 cycle, ready=0. mem[addr] <= shift reg.
  - burst input=1: addr <= addr+1, wrapping mod 2^ADDR_WIDTH; goes to WDATA.
  - else goes to IDLE.
- RFETCH: exactly 1 cycle, ready=0. Read shift reg <= mem[addr] (registered read).
- RDATA: ready=0, valid_out=1, data_out=shift reg MSB. Shifts every cycle for exactly DATA_WIDTH cycles; no back-pressure.
  - After the last bit, burst input=1: addr+1 with wrap, goes to RFETCH.
  - else goes to IDLE.
  - Read latency: first data_out bit is 2 cycles after the cycle carrying the final address bit.
- valid, address and data are ignored in WCOMMIT, RFETCH and RDATA.
- Timeout: idle_cnt counts consecutive valid=0 cycles in ADDR/WDATA and clears on valid=1.
  - On reaching TIMEOUT: goes to IDLE, no memory write, partial word discarded.
  - Covers the master releasing the bus mid-transfer.
- Burst write timing: the first bit of the next word may arrive the cycle after WCOMMIT. A bit presented during WCOMMIT is lost; the master must watch ready.
- Reset mid-operation: immediate return to the reset values above. Any in-flight write that has not reached WCOMMIT is dropped.
- write_en and burst are not re-sampled inside a burst, except burst at each word boundary.

Decomposition:
- Shared package bus_pkg:
  - state encodings (slave_state_t)
  - default ADDR_WIDTH and DATA_WIDTH constants shared with master and arbiter blocks
- One sub-module, slave_memory: 2^ADDR_WIDTH x DATA_WIDTH, synchronous write, registered read, no reset.
- FSM, shift registers and counters stay in serial_slave_port.

Test Plan:
- Single write then read, defaults:
  - Write 0xA5 to addr 0x155 (11 address bits, then 8 data bits, valid=1 throughout).
  - Read 0x155 -> valid_out high 8 cycles, data_out = 1,0,1,0,0,1,0,1.
  - First bit arrives 2 cycles after the last address bit.
- Burst write with wrap:
  - Start at addr 0x7FF, burst=1, words 0x11,0x22,0x33; burst=0 at the third boundary.
  - Reads return 0x11@0x7FF, 0x22@0x000, 0x33@0x001; state returns to IDLE.
- Stall then resume:
  - valid low 3 cycles after address bit 5, then continue -> correct address, write lands correctly.
- Timeout abort:
  - valid low 16 cycles after data bit 4 -> state=IDLE, target word keeps its prior value, ready=1.
- Reset mid-RDATA:
  - reset low during bit 3 of a read -> valid_out=0, data_out=0, ready=0 asynchronously.
  - After release: ready=1 in IDLE; previously written memory data still reads back intact.
- Ignored inputs:
  - Toggle valid/address during RFETCH and RDATA -> read stream unaffected, no state change, no spurious write.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared serial-bus definitions: slave FSM encodings and the
//               default address/data widths used by master, arbiter and slave.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_addr_width = 11;
    localparam int c_data_width = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_WCOMMIT = 3'd3,
        ST_RFETCH  = 3'd4,
        ST_RDATA   = 3'd5
    } slave_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_slave_port_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_slave_port_if
// Description : Bit-serial bus between an arbiter slave port and a slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_slave_port_if;

    logic address;
    logic data;
    logic valid;
    logic write_en;
    logic burst;
    logic data_out;
    logic ready;
    logic valid_out;

    modport master (
        output address, data, valid, write_en, burst,
        input  data_out, ready, valid_out
    );

    modport slave (
        input  address, data, valid, write_en, burst,
        output data_out, ready, valid_out
    );

endinterface
`default_nettype wire

// File: rtl/slave_memory.sv
`default_nettype none
// ============================================================================
// Module      : slave_memory
// Description : 2^ADDR_WIDTH x DATA_WIDTH storage, synchronous write,
//               registered read, contents never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_memory
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/serial_slave_port.sv
`default_nettype none
// ============================================================================
// Module      : serial_slave_port
// Description : Serial bus slave endpoint: deserialises address/write data into
//               local memory and serialises read data back, with bursts/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_slave_port_if.slave   bus,
    output logic [2:0]           state
);

    localparam int c_cnt_w  = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
    localparam int c_idle_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]  c_addr_last = c_cnt_w'(ADDR_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_data_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT - 1);

    slave_state_t            r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wshift;
    logic [DATA_WIDTH-1:0]   r_rshift;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic [c_idle_w-1:0]     r_idle_cnt;
    logic                    r_write;
    logic                    r_ready;
    logic                    r_valid_out;
    logic                    r_data_out;

    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [DATA_WIDTH-1:0]   w_rshift;
    logic [DATA_WIDTH-1:0]   w_mem_rdata;
    logic                    w_mem_we;

    // The memory read port is fed the next-cycle address, so the registered
    // read data is already valid during RFETCH and the shift load needs no
    // extra cycle.
    always_comb begin
        w_addr_next = r_addr;
        case (r_state)
            ST_IDLE:    if (bus.valid) w_addr_next = ADDR_WIDTH'(bus.address);
            ST_ADDR:    if (bus.valid) w_addr_next = ADDR_WIDTH'({r_addr, bus.address});
            ST_WCOMMIT: if (bus.burst) w_addr_next = r_addr + 1'b1;
            ST_RDATA:   if (bus.burst && (r_bit_cnt == c_data_last)) w_addr_next = r_addr + 1'b1;
            default:    ;
        endcase
    end

    assign w_rshift = r_rshift << 1;
    assign w_mem_we = (r_state == ST_WCOMMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wshift    <= '0;
            r_rshift    <= '0;
            r_bit_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_write     <= 1'b0;
            r_ready     <= 1'b0;
            r_valid_out <= 1'b0;
            r_data_out  <= 1'b0;
        end else begin
            r_addr <= w_addr_next;
            case (r_state)
                ST_IDLE: begin
                    r_ready     <= 1'b1;
                    r_valid_out <= 1'b0;
                    r_data_out  <= 1'b0;
                    r_idle_cnt  <= '0;
                    if (bus.valid) begin
                        r_write   <= bus.write_en;
                        r_bit_cnt <= c_cnt_w'(1);
                        if (ADDR_WIDTH == 1) begin
                            r_bit_cnt <= '0;
                            if (bus.write_en) begin
                                r_state <= ST_WDATA;
                            end else begin
                                r_state <= ST_RFETCH;
                                r_ready <= 1'b0;
                            end
                        end else begin
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.valid) begin
                        r_idle_cnt <= '0;
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_addr_last) begin
                            r_bit_cnt <= '0;
                            if (r_write) begin
                                r_state <= ST_WDATA;
                            end else begin
                                r_state <= ST_RFETCH;
                                r_ready <= 1'b0;
                            end
                        end
                    end else if (r_idle_cnt == c_idle_last) begin
                        r_state    <= ST_IDLE;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (bus.valid) begin
                        r_idle_cnt <= '0;
                        r_wshift   <= DATA_WIDTH'({r_wshift, bus.data});
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_WCOMMIT;
                            r_ready   <= 1'b0;
                        end
                    end else if (r_idle_cnt == c_idle_last) begin
                        // Master walked away: the partial word is simply never committed.
                        r_state    <= ST_IDLE;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                ST_WCOMMIT: begin
                    r_ready    <= 1'b1;
                    r_idle_cnt <= '0;
                    r_state    <= bus.burst ? ST_WDATA : ST_IDLE;
                end
                ST_RFETCH: begin
                    r_rshift    <= w_mem_rdata;
                    r_data_out  <= w_mem_rdata[DATA_WIDTH-1];
                    r_valid_out <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_state     <= ST_RDATA;
                end
                ST_RDATA: begin
                    if (r_bit_cnt == c_data_last) begin
                        r_valid_out <= 1'b0;
                        r_data_out  <= 1'b0;
                        r_bit_cnt   <= '0;
                        if (bus.burst) begin
                            r_state <= ST_RFETCH;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_rshift   <= w_rshift;
                        r_data_out <= w_rshift[DATA_WIDTH-1];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    slave_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_addr),
        .i_wr_data (r_wshift),
        .i_rd_addr (w_addr_next),
        .o_rd_data (w_mem_rdata)
    );

    assign bus.ready     = r_ready;
    assign bus.valid_out = r_valid_out;
    assign bus.data_out  = r_data_out;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_serial_slave_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_slave_port
// Description : Self-checking bench for serial_slave_port (vector table plus
//               read-data scoreboard and multi-cycle corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_slave_port;

    localparam int AW = 11;
    localparam int DW = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] state;

    serial_slave_port_if bus_if();

    serial_slave_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .state (state)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read-data scoreboard: assemble each 8-bit valid_out run, compare to queue head
    int            mon_cnt = 0;
    logic [DW-1:0] mon_word = '0;
    logic [DW-1:0] mon_exp;
    always @(negedge clk) begin
        if (!reset) begin
            mon_cnt = 0;
        end else if (bus_if.valid_out) begin
            mon_word = {mon_word[DW-2:0], bus_if.data_out};
            mon_cnt++;
            if (mon_cnt == DW) begin
                mon_cnt = 0;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read: got 0x%0h, expected no read", mon_word);
                end else begin
                    mon_exp = sb.pop_front();
                    check("read_word", 32'(mon_word), 32'(mon_exp));
                end
            end
        end else if (mon_cnt != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_out_len: got %0d bits, expected %0d", mon_cnt, DW);
            mon_cnt = 0;
        end
    end

    task automatic drive_addr(input logic we, input logic [AW-1:0] a, input logic b);
        for (int i = AW - 1; i >= 0; i--) begin
            @(negedge clk);
            bus_if.valid    = 1'b1;
            bus_if.write_en = we;
            bus_if.burst    = b;
            bus_if.address  = a[i];
        end
    endtask

    task automatic drive_data(input logic [DW-1:0] d, input logic b);
        for (int i = DW - 1; i >= 0; i--) begin
            @(negedge clk);
            bus_if.valid = 1'b1;
            bus_if.data  = d[i];
            bus_if.burst = b;
        end
    endtask

    task automatic end_word();
        @(negedge clk);
        bus_if.valid = 1'b0;
        check("wcommit_state", 32'(state), 32'd3);
        check("wcommit_ready", 32'(bus_if.ready), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(state == 3'd0 && sb.size() == 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 40), 32'd1);
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive_addr(1'b1, a, 1'b0);
        drive_data(d, 1'b0);
        end_word();
    endtask

    task automatic read_word(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        sb.push_back(exp);
        drive_addr(1'b0, a, 1'b0);
        @(negedge clk);
        bus_if.valid = 1'b0;
        wait_idle("read_done");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   seen;
        int   n;

        tbl[0] = '{we: 1'b1, addr: 11'h000, data: 8'hFF};
        tbl[1] = '{we: 1'b1, addr: 11'h7FE, data: 8'h00};
        tbl[2] = '{we: 1'b1, addr: 11'h400, data: 8'h81};
        tbl[3] = '{we: 1'b0, addr: 11'h000, data: 8'hFF};
        tbl[4] = '{we: 1'b0, addr: 11'h7FE, data: 8'h00};
        tbl[5] = '{we: 1'b0, addr: 11'h400, data: 8'h81};
        tbl[6] = '{we: 1'b1, addr: 11'h000, data: 8'h6E};
        tbl[7] = '{we: 1'b0, addr: 11'h000, data: 8'h6E};

        bus_if.valid    = 1'b0;
        bus_if.address  = 1'b0;
        bus_if.data     = 1'b0;
        bus_if.write_en = 1'b0;
        bus_if.burst    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(bus_if.ready), 32'd0);
        check("rst_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("rst_data_out", 32'(bus_if.data_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus_if.ready), 32'd1);
        check("post_rst_state", 32'(state), 32'd0);

        // Table of single writes and reads
        for (int v = 0; v < 8; v++) begin
            if (tbl[v].we) write_word(tbl[v].addr, tbl[v].data);
            else           read_word(tbl[v].addr, tbl[v].data);
        end

        // Single write then read with latency checks
        write_word(11'h155, 8'hA5);
        sb.push_back(8'hA5);
        drive_addr(1'b0, 11'h155, 1'b0);
        @(negedge clk);
        bus_if.valid = 1'b0;
        check("lat_rfetch_state", 32'(state), 32'd4);
        check("lat_valid_out_low", 32'(bus_if.valid_out), 32'd0);
        @(negedge clk);
        check("lat_valid_out_high", 32'(bus_if.valid_out), 32'd1);
        check("lat_rdata_state", 32'(state), 32'd5);
        wait_idle("read_a5_done");

        // Burst write across the address wrap
        drive_addr(1'b1, 11'h7FF, 1'b1);
        drive_data(8'h11, 1'b1);
        end_word();
        drive_data(8'h22, 1'b1);
        end_word();
        drive_data(8'h33, 1'b0);
        end_word();
        @(negedge clk);
        check("burst_wr_idle", 32'(state), 32'd0);
        read_word(11'h7FF, 8'h11);
        read_word(11'h000, 8'h22);
        read_word(11'h001, 8'h33);

        // Burst read across the wrap, burst dropped during the second word
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        drive_addr(1'b0, 11'h7FF, 1'b1);
        @(negedge clk);
        bus_if.valid = 1'b0;
        seen = 0;
        n    = 0;
        while (seen < 9 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus_if.valid_out) seen++;
        end
        bus_if.burst = 1'b0;
        check("burst_rd_bound", 32'(n < 40), 32'd1);
        wait_idle("burst_rd_done");

        // Stall of 3 cycles after address bit 5
        for (int i = AW - 1; i >= 0; i--) begin
            @(negedge clk);
            bus_if.valid    = 1'b1;
            bus_if.write_en = 1'b1;
            bus_if.burst    = 1'b0;
            bus_if.address  = 11'h2AA >> i;
            if (i == AW - 5) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    bus_if.valid   = 1'b0;
                    bus_if.address = ~bus_if.address;
                    if (k == 2) check("stall_hold", 32'(state), 32'd1);
                end
            end
        end
        drive_data(8'h3C, 1'b0);
        end_word();
        read_word(11'h2AA, 8'h3C);

        // Timeout abort after data bit 4
        write_word(11'h0F0, 8'h5A);
        drive_addr(1'b1, 11'h0F0, 1'b0);
        for (int i = 7; i >= 4; i--) begin
            @(negedge clk);
            bus_if.valid = 1'b1;
            bus_if.data  = 8'hC3 >> i;
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus_if.valid = 1'b0;
            if (k == 16) check("timeout_pre_state", 32'(state), 32'd2);
        end
        @(negedge clk);
        check("timeout_state", 32'(state), 32'd0);
        check("timeout_ready", 32'(bus_if.ready), 32'd1);
        read_word(11'h0F0, 8'h5A);

        // Ignored inputs during RFETCH and RDATA
        sb.push_back(8'h3C);
        drive_addr(1'b0, 11'h2AA, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("ign_state", 32'(state), (i == 1) ? 32'd4 : 32'd5);
            bus_if.valid    = 1'($urandom_range(0, 1));
            bus_if.address  = 1'($urandom_range(0, 1));
            bus_if.data     = 1'($urandom_range(0, 1));
            bus_if.write_en = 1'b1;
            bus_if.burst    = 1'b0;
        end
        @(negedge clk);
        bus_if.valid = 1'b0;
        check("ign_idle", 32'(state), 32'd0);
        check("ign_sb_empty", 32'(sb.size()), 32'd0);
        read_word(11'h2AA, 8'h3C);

        // Reset during bit 3 of a read
        sb.push_back(8'hA5);
        drive_addr(1'b0, 11'h155, 1'b0);
        @(negedge clk);
        bus_if.valid = 1'b0;
        seen = 0;
        n    = 0;
        while (seen < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus_if.valid_out) seen++;
        end
        check("rst_mid_bound", 32'(n < 40), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_valid_out", 32'(bus_if.valid_out), 32'd0);
        check("rst_mid_data_out", 32'(bus_if.data_out), 32'd0);
        check("rst_mid_ready", 32'(bus_if.ready), 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(bus_if.ready), 32'd1);
        check("rst_rel_state", 32'(state), 32'd0);
        read_word(11'h155, 8'hA5);
        read_word(11'h001, 8'h33);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
